if_unit: RTL



---
 rtl/cpu_pkg.sv | 9 +
 rtl/if_id_reg.sv | 31 +++
 rtl/if_unit.sv | 96 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, default NOP and fetch-state encoding for the pipelined CPU
package cpu_pkg;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [15:0] DEFAULT_NOP = 16'h0000;
  typedef enum logic [1:0] {FETCH, HOLD, HALT} fetchState_t;
  function automatic logic isHlt(input logic [15:0] inst);
    return inst[15:12] == OP_HLT;
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with flush > hold > load priority; idle cycles insert a bubble
module if_id_reg #(
  parameter int W = 16,
  parameter logic [W-1:0] RESET_INST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         hold,
  input  logic         flush,
  input  logic [W-1:0] instIn,
  input  logic [W-1:0] pcPlus2In,
  input  logic         validIn,
  output logic [W-1:0] inst,
  output logic [W-1:0] pcPlus2,
  output logic         valid
);
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      inst <= RESET_INST;
      pcPlus2 <= '0;
      valid <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        inst <= instIn;
        pcPlus2 <= pcPlus2In;
      end
      valid <= load & validIn;
    end
  end
endmodule

// File: rtl/if_unit.sv
// if_unit: instruction fetch stage (PC, imem handshake, IF/ID register, stall/redirect/HLT).
// Define IF_PERF_CNT_EN to add fetch_count and stall_cycles performance counters.
module if_unit
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = DEFAULT_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [15:0] inst_ID,
  output logic [15:0] pc_plus2_ID,
  output logic        valid_ID,
  output logic        halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_cycles
`endif
);
  fetchState_t state, nextState;
  logic [15:0] pc, nextPc, holdBuf, pcPlus2, loadInst;
  logic load, hold, flush, capture, wordReady;
  assign pcPlus2 = pc + 16'd2;
  assign loadInst = (state == HOLD) ? holdBuf : imem_rdata;
  assign wordReady = (state == HOLD) || imem_rvalid;
  assign imem_req = rst_n && (state == FETCH);
  assign imem_addr = pc;
  assign halted = state == HALT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc <= RESET_PC;
      holdBuf <= NOP_INST;
    end else begin
      state <= nextState;
      pc <= nextPc;
      if (capture) holdBuf <= imem_rdata;
    end
  end
  // Redirect overrides everything; HALT with no redirect just bubbles IF/ID.
  always_comb begin
    nextState = state;
    nextPc = pc;
    load = 1'b0;
    hold = 1'b0;
    flush = 1'b0;
    capture = 1'b0;
    if (redirect) begin
      flush = 1'b1;
      nextPc = redirect_pc;
      nextState = FETCH;
    end else if (state != HALT) begin
      if (stall) begin
        hold = 1'b1;
        capture = (state == FETCH) && imem_rvalid;
        nextState = wordReady ? HOLD : FETCH;
      end else if (wordReady) begin
        load = 1'b1;
        nextPc = isHlt(loadInst) ? pc : pcPlus2;
        nextState = isHlt(loadInst) ? HALT : FETCH;
      end
    end
  end
  if_id_reg #(.W(16), .RESET_INST(NOP_INST)) ifId (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .hold(hold),
    .flush(flush),
    .instIn(loadInst),
    .pcPlus2In(pcPlus2),
    .validIn(1'b1),
    .inst(inst_ID),
    .pcPlus2(pc_plus2_ID),
    .valid(valid_ID)
  );
`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_cycles <= '0;
    end else begin
      if (load) fetch_count <= fetch_count + 16'd1;
      if (stall) stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif
endmodule
